turbo_puncture: RTL

Puncturing stage directly upstream of the turbo output controller. It takes the 4-bit parity words from RSC1 and RSC2 for one frame and alternately keeps one of them according to a programmable pattern, producing one punctured parity word per systematic word. It also generates the d_start/d_over framing that the output controller uses to buffer the punctured words and then interleave them with the systematic stream.

---
 rtl/turbo_puncture.sv | 121 ++++++++++++
 1 files changed

// File: rtl/turbo_puncture.sv
// Parity puncturing stage: keeps p1 or p2 per word according to PAT and
// frames the punctured frame with d_start/d_over for the output controller.
module turbo_puncture #(
    parameter int unsigned N    = 16,
    parameter int unsigned W    = 4,
    parameter logic [1:0]  PAT  = 2'b01,
    parameter int unsigned HOLD = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_start,
    input  logic         in_valid,
    input  logic [W-1:0] p1,
    input  logic [W-1:0] p2,
    output logic [W-1:0] delete_out,
    output logic         d_valid,
    output logic         d_start,
    output logic         d_over,
    output logic         err
);

    localparam int unsigned KW = $clog2(N) + 1;
    localparam int unsigned HW = $clog2(HOLD) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           dvalid_q, dvalid_d;
    logic           dstart_q, dstart_d;
    logic           dover_q, dover_d;
    logic           err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            k_q      <= '0;
            hold_q   <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            dstart_q <= 1'b0;
            dover_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            hold_q   <= hold_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            dstart_q <= dstart_d;
            dover_q  <= dover_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        hold_d   = hold_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        dstart_d = dstart_q;
        dover_d  = dover_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) err_d = 1'b1;
                if (frame_start) begin
                    state_d = StRun;
                    k_d     = '0;
                end
            end
            StRun: begin
                // A restart takes priority over any word presented in the same cycle
                if (frame_start) begin
                    err_d = 1'b1;
                    k_d   = '0;
                end else if (in_valid) begin
                    dout_d   = PAT[k_q[0]] ? p1 : p2;
                    dvalid_d = 1'b1;
                    dstart_d = 1'b1;
                    if (k_q == KW'(N - 1)) begin
                        state_d = StDone;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (in_valid) err_d = 1'b1;
                if (frame_start) begin
                    dover_d  = 1'b0;
                    dstart_d = 1'b0;
                    state_d  = StRun;
                    k_d      = '0;
                end else if (!dover_q) begin
                    // First DONE cycle: d_over is only ever low here on entry
                    dstart_d = 1'b0;
                    dover_d  = 1'b1;
                    hold_d   = '0;
                end else if (hold_q == HW'(HOLD - 1)) begin
                    dover_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign delete_out = dout_q;
    assign d_valid    = dvalid_q;
    assign d_start    = dstart_q;
    assign d_over     = dover_q;
    assign err        = err_q;

endmodule
